// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - collects a group of operand words into packed lanes and presents them as one block
// Unwritten lanes read all ones so short groups feed an AND reduction unchanged.
module operand_loader #(
  parameter int NUM   = 8,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [NUM*WIDTH-1:0]       out_data,
  output logic [$clog2(NUM+1)-1:0]   out_count,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int IW = $clog2(NUM);
  localparam int CW = $clog2(NUM+1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        count_q, count_d;
  logic [NUM*WIDTH-1:0] lanes_q, lanes_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      count_q <= '0;
      lanes_q <= '1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      lanes_q <= lanes_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    lanes_d = lanes_q;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          for (int k = 0; k < NUM; k++) begin
            if (idx_q == IW'(k)) begin
              lanes_d[k*WIDTH +: WIDTH] = in_data;
            end
          end
          idx_d = idx_q + IW'(1);
          // Group closes on whichever comes first: last lane filled or in_last.
          if (idx_q == IW'(NUM-1) || in_last) begin
            state_d = HOLD;
            count_d = CW'(idx_q) + CW'(1);
            idx_d   = '0;
          end
        end
      end
      HOLD: begin
        // No bypass: input is ignored on the handoff edge itself.
        if (out_ready) begin
          state_d = FILL;
          idx_d   = '0;
          count_d = '0;
          lanes_d = '1;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign out_data  = lanes_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - directed and random checks of operand_loader against a queue-based group model
module tb_operand_loader;

  localparam int NUM   = 8;
  localparam int WIDTH = 32;

  logic                 clk;
  logic                 rst;
  logic [WIDTH-1:0]     in_data;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic [NUM*WIDTH-1:0] out_data;
  logic [3:0]           out_count;
  logic                 out_valid;
  logic                 out_ready;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: words of the current group, and whether it is being presented.
  logic [WIDTH-1:0] grp[$];
  bit               m_hold;

  operand_loader #(.NUM(NUM), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NUM*WIDTH-1:0] model_data();
    logic [NUM*WIDTH-1:0] d;
    d = '1;
    for (int i = 0; i < grp.size(); i++) d[i*WIDTH +: WIDTH] = grp[i];
    return d;
  endfunction

  task automatic check(input string tag, input logic [NUM*WIDTH-1:0] obs,
                       input logic [NUM*WIDTH-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"}, (NUM*WIDTH)'(out_valid), (NUM*WIDTH)'(m_hold));
    check({tag, ".in_ready"},  (NUM*WIDTH)'(in_ready),  (NUM*WIDTH)'(!m_hold));
    check({tag, ".out_count"}, (NUM*WIDTH)'(out_count),
          (NUM*WIDTH)'(m_hold ? grp.size() : 0));
    check({tag, ".out_data"},  out_data, model_data());
  endtask

  task automatic model_reset();
    grp.delete();
    m_hold = 1'b0;
  endtask

  // One rising edge: advance the model with the inputs seen at the edge, then compare.
  task automatic step(input string tag);
    @(posedge clk);
    if (!rst) begin
      if (!m_hold) begin
        if (in_valid) begin
          grp.push_back(in_data);
          if (in_last || grp.size() == NUM) m_hold = 1'b1;
        end
      end else if (out_ready) begin
        grp.delete();
        m_hold = 1'b0;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    check({tag, ".ones"}, out_data, {(NUM*WIDTH){1'b1}});
  endtask

  logic [NUM*WIDTH-1:0] seq_exp;
  logic [NUM*WIDTH-1:0] held;

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    #1;
    check_all("por");
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;

    for (int k = 0; k < NUM; k++) seq_exp[k*WIDTH +: WIDTH] = WIDTH'(k+1);

    // Full group, back to back, consumer stalled
    for (int k = 0; k < NUM; k++) begin
      in_valid = 1'b1; in_data = WIDTH'(k+1);
      step("full.fill");
    end
    in_valid = 1'b0;
    check("full.lanes", out_data, seq_exp);
    check("full.count", (NUM*WIDTH)'(out_count), (NUM*WIDTH)'(8));
    step("full.stall");
    out_ready = 1'b1;
    step("full.drain");
    out_ready = 1'b0;
    check("full.cleared", out_data, {(NUM*WIDTH){1'b1}});

    // Short group closed by in_last; in_last without in_valid is ignored first
    in_last = 1'b1; step("short.idle_last");
    in_last = 1'b0;
    in_valid = 1'b1; in_data = 32'hFFFF_0000; step("short.w0");
    in_last = 1'b1;  in_data = 32'h0000_FFFF; step("short.w1");
    in_valid = 1'b0; in_last = 1'b0;
    check("short.count", (NUM*WIDTH)'(out_count), (NUM*WIDTH)'(2));
    check("short.hi_lanes", out_data[NUM*WIDTH-1:2*WIDTH], {((NUM-2)*WIDTH){1'b1}});

    // Backpressure: input ignored during HOLD and on the handoff edge
    held = out_data;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) step("bp.hold");
    check("bp.stable", out_data, held);
    out_ready = 1'b1; step("bp.handoff");
    out_ready = 1'b0; step("bp.accept");
    in_valid = 1'b0;
    check("bp.lane0", (NUM*WIDTH)'(out_data[WIDTH-1:0]), (NUM*WIDTH)'(32'hDEAD_BEEF));
    // Finish this group with in_last on the NUM-th word and drain it
    for (int k = 1; k < NUM; k++) begin
      in_valid = 1'b1; in_last = (k == NUM-1); in_data = $urandom; step("bp.rest");
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; step("bp.drain"); out_ready = 1'b0;

    // Gapped input, out_ready high during FILL has no effect
    out_ready = 1'b1;
    for (int k = 0; k < NUM; k++) begin
      in_valid = 1'b1; in_data = WIDTH'(k+1); step("gap.on");
      if (k != NUM-1) begin
        in_valid = 1'b0; in_data = 32'h5555_5555; step("gap.off");
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("gap.lanes", out_data, seq_exp);
    out_ready = 1'b1; step("gap.drain"); out_ready = 1'b0;

    // Reset after three accepted words aborts the group
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = $urandom; step("mid.fill");
    end
    in_valid = 1'b0;
    async_reset("mid.rst");
    step("mid.in_rst");
    rst = 1'b0;
    in_valid = 1'b1; in_data = 32'h1234_5678; step("mid.restart");
    in_valid = 1'b0;
    check("mid.lane0", (NUM*WIDTH)'(out_data[WIDTH-1:0]), (NUM*WIDTH)'(32'h1234_5678));

    // Reset during HOLD
    for (int k = 0; k < NUM; k++) begin
      in_valid = 1'b1; in_data = $urandom; step("hold.fill");
    end
    in_valid = 1'b0;
    async_reset("hold.rst");
    #1; rst = 1'b0;
    step("hold.after");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 2) == 0);
      in_data   = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd.rst");
        step("rnd.in_rst");
        rst = 1'b0;
      end else begin
        step("rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter NUM, default 8: number of output lanes (operands); legal range 2..16.
REQ-002 Parameter WIDTH, default 32: bits per lane.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_data  input  WIDTH  incoming operand word.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_last  input  1  final word of the current group; qualified by in_valid.
REQ-009 in_ready  output  1  block can accept a word this cycle.
REQ-010 out_data  output  NUM*WIDTH  packed lanes; lane k occupies bits [k*WIDTH +: WIDTH]; lane 0 is the first word received.
REQ-011 out_count  output  $clog2(NUM+1)  number of words loaded into the presented group.
REQ-012 out_valid  output  1  out_data/out_count hold a complete group.
REQ-013 out_ready  input  1  downstream consumes the group.

Function
REQ-014 A word SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-015 Two states: FILL (collecting) and HOLD (presenting); in_ready = (state==FILL), combinational from state only; out_valid = (state==HOLD), registered.
REQ-016 In FILL, an accepted word SHALL be written into lane idx; idx increments by 1 (idx width $clog2(NUM)).
REQ-017 Lanes not written in the current group SHALL read all ones (the AND identity), so a short group feeds an AND reduction correctly.
REQ-018 FILL -> HOLD on the edge that accepts a word with idx==NUM-1 or in_last==1, whichever occurs first; out_count is set to idx+1 on that edge.
REQ-019 out_valid SHALL rise the cycle after the accepting edge of the final word (latency 1 clk); out_data is stable throughout HOLD.
REQ-020 HOLD -> FILL on an edge with out_valid && out_ready; on that edge all lanes are set to all ones, idx and out_count are set to 0.
REQ-021 No bypass: in HOLD, in_ready is 0 and input is ignored even if out_ready is 1 in the same cycle; the next group begins accepting in the cycle after the handoff.
REQ-022 out_ready while in FILL SHALL have no effect.
REQ-023 in_last with in_valid low SHALL be ignored; in_last on the NUM-th word is equivalent to the NUM-th word without in_last.
REQ-024 Minimum throughput: one group per (words+1) cycles with out_ready held high.

Reset
REQ-025 While rst is high, and immediately on its assertion, irrespective of clk: state=FILL, idx=0, out_count=0, out_valid=0, all out_data bits=1; in_ready=1.
REQ-026 Reset asserted mid-group or during HOLD SHALL discard the partial/presented group with no output handshake.
REQ-027 First acceptance is possible on the first rising edge after rst deasserts.

Verification (NUM=8, WIDTH=32)
REQ-028 Reset: assert rst between edges -> out_valid=0, in_ready=1, out_data=256'hFF..FF, out_count=0 without a clock edge.
REQ-029 Full group: 8 words 32'h0000_0001..32'h0000_0008 back-to-back, out_ready=0 -> out_valid=1 one cycle after the 8th accept, lane k = k+1, out_count=8, in_ready=0; after out_ready=1 for one edge -> out_valid=0, in_ready=1, lanes all ones.
REQ-030 Short group: 2 words 32'hFFFF_0000, 32'h0000_FFFF with in_last on the second -> out_count=2, lanes 0/1 as sent, lanes 2..7 = 32'hFFFF_FFFF.
REQ-031 Backpressure: in HOLD drive in_valid=1 with 32'hDEAD_BEEF for 5 cycles -> out_data unchanged, no acceptance; release out_ready -> DEAD_BEEF is accepted into lane 0 starting the cycle after the handoff.
REQ-032 Gapped input: in_valid toggled 1/0 per cycle over 8 words -> same result as REQ-029, idx advances only on accepting edges.
REQ-033 Reset mid-operation: assert rst after 3 accepted words -> next group after release starts at lane 0; no out_valid pulse from the aborted group.
